reset_pulse_ctrl: RTL and testbench
===================================

Name: reset_pulse_ctrl

Overview:
Parametrised successor to the fixed two-line DC/optional reset counters and the status-LED mux in the control-clock area.
- Provides N_CH independent, retriggerable open-drain reset pulse channels of configurable length, with optional power-on assertion.
- Provides a registered status-LED selector that shows either the board status (glow patterns) or a mirror of any reset channel.
- Sits in the control-clock domain; all inputs arrive already synchronised (Flag_CrossDomain / Signal_CrossDomain / data_cross).

Parameters:
N_CH, 2, number of reset channels (1..8)
PULSE_CYCLES, 8_000_000, low time per reset pulse in clock cycles (>=2)
POWERON_ASSERT, 0, 1 = every channel starts a pulse when reset releases
SLOW_BITPOS, 26, glow counter bit for slow glow period
FAST_BITPOS, 22, glow counter bit for fast glow period (< SLOW_BITPOS, >= 8)

Ports:
clock  in  1  control clock
reset  in  1  asynchronous, active-high
reset_req  in  N_CH  single-cycle request pulse per channel
nreset_drive_low  out  N_CH  1 = top level pulls line low, 0 = Hi-Z
busy  out  N_CH  1 while the channel's pulse is in progress
led_conf  in  8  LED source: 0 = status, 1..N_CH = mirror channel led_conf-1, other = Hi-Z
pll_ready  in  1  HDMI PLL locked
resync_active  in  1  resync or force_generate in progress
adv_ready  in  1  ADV7513 configured
status_led_oe  out  1  1 = drive status_led_val, 0 = Hi-Z
status_led_val  out  1  LED pin value when driven

Behaviour:
- Reset values:
  - nreset_drive_low = busy = {N_CH{POWERON_ASSERT}}.
  - Channel counters = 0.
  - Glow counter = 0.
  - status_led_oe = 0, status_led_val = 0.
- Per-channel FSM, states IDLE and ASSERT:
  - Counter width is $clog2(PULSE_CYCLES+1).
  - IDLE: counter held at 0; a reset_req[i] sampled high moves the channel to ASSERT with counter = 0.
  - ASSERT: counter increments each cycle. When counter == PULSE_CYCLES-1, the channel returns to IDLE.
  - Net effect: for a request at edge k, drive_low is 1 from after edge k through edge k+PULSE_CYCLES, i.e. exactly PULSE_CYCLES cycles.
  - reset_req[i] high while in ASSERT (including the final cycle) clears the counter to 0 and stays in ASSERT (retrigger). Low time then extends to PULSE_CYCLES after the last request.
  - busy[i] == nreset_drive_low[i] at all times.
  - Channels are fully independent; simultaneous requests on several channels all start in the same cycle.
  - The counter never free-runs or wraps in IDLE.
- Glow generator:
  - One free-running counter of SLOW_BITPOS+1 bits; wraps naturally.
  - For B in {SLOW_BITPOS, FAST_BITPOS}, level = cnt[B-1:B-8], inverted when cnt[B] = 1 (triangle).
  - glow_B = (cnt[7:0] < level).
- LED mux (registered, 1-cycle latency from any input change):
  - led_conf == 0: status_led_oe = 1. status_led_val, first match wins:
    - !pll_ready → 1
    - resync_active → ~fast_glow
    - adv_ready → 0
    - else ~slow_glow
  - 1 <= led_conf <= N_CH: status_led_oe = nreset_drive_low[led_conf-1], status_led_val = 0 (open-drain mirror).
  - led_conf > N_CH: status_led_oe = 0, status_led_val = 0.
  - led_conf may change any cycle; the new selection takes effect on the next edge.
- Reset asserted mid-pulse: outputs return to reset values immediately (asynchronous). With POWERON_ASSERT = 1, a fresh full pulse begins on release.

Decomposition:
- Shared package (the existing config include/package) holds:
  - LED_CONF_STATUS = 8'd0.
  - Default pulse length constant RESET_PULSE_CYCLES = 8_000_000.
- Natural sub-module: led_glow_pwm (counter + triangle PWM for both bit positions). It replaces the two LEDglow instances with one shared counter.
- Per-channel logic is a generate loop, not a sub-module.

Test Plan:
1. N_CH=2, PULSE_CYCLES=8: reset_req=2'b01 pulse at edge 10 → nreset_drive_low[0]=1 on edges 11..18, 0 from edge 19; channel 1 stays 0.
2. Retrigger: req[0] at edge 10 and again at edge 15 → drive_low[0] high through edge 23; busy[0] tracks it exactly.
3. Simultaneous: req=2'b11 at edge 5 while reset pulses high at edge 8 for 1 cycle → both outputs 0 immediately; with POWERON_ASSERT=1, both high for exactly 8 cycles after release.
4. led_conf=0:
   - pll_ready=0 → oe=1, val=1 one cycle later.
   - pll_ready=1, resync_active=1 → val follows ~fast_glow (check against reference model with FAST_BITPOS=9).
   - adv_ready=1, resync_active=0 → val=0.
5. led_conf=2 during a channel-1 pulse → oe=1, val=0 for the pulse, oe=0 afterwards; led_conf=3 → oe=0 constantly.
6. Glow counter wrap (SLOW_BITPOS=10): run 4096 cycles → slow_glow duty rises then falls symmetrically, no glitch at wrap.

Source files
------------

// File: rtl/reset_pulse_ctrl_pkg.sv
// Shared constants and types for the control-clock reset pulse / status LED block.
package reset_pulse_ctrl_pkg;

    localparam logic [7:0] LED_CONF_STATUS    = 8'd0;
    localparam int         RESET_PULSE_CYCLES = 8_000_000;

    typedef enum logic {
        CH_IDLE,
        CH_ASSERT
    } ch_state_t;

endpackage

// File: rtl/led_glow_pwm.sv
// One free-running counter driving triangle-wave PWM "glow" at two periods.
module led_glow_pwm #(
    parameter int SLOW_BITPOS = 26,
    parameter int FAST_BITPOS = 22
) (
    input  logic clock,
    input  logic reset,
    output logic slow_glow,
    output logic fast_glow
);

    logic [SLOW_BITPOS:0] cnt;
    logic [7:0]           slow_level;
    logic [7:0]           fast_level;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt <= '0;
        else       cnt <= cnt + {{SLOW_BITPOS{1'b0}}, 1'b1};
    end

    // Top bit of each window folds the ramp back down, giving a triangle brightness.
    assign slow_level = cnt[SLOW_BITPOS-1 -: 8] ^ {8{cnt[SLOW_BITPOS]}};
    assign fast_level = cnt[FAST_BITPOS-1 -: 8] ^ {8{cnt[FAST_BITPOS]}};

    assign slow_glow = (cnt[7:0] < slow_level);
    assign fast_glow = (cnt[7:0] < fast_level);

endmodule

// File: rtl/reset_pulse_ctrl.sv
// N_CH retriggerable open-drain reset pulse channels plus a registered status-LED selector.
module reset_pulse_ctrl
    import reset_pulse_ctrl_pkg::*;
#(
    parameter int N_CH           = 2,
    parameter int PULSE_CYCLES   = RESET_PULSE_CYCLES,
    parameter bit POWERON_ASSERT = 1'b0,
    parameter int SLOW_BITPOS    = 26,
    parameter int FAST_BITPOS    = 22
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N_CH-1:0] reset_req,
    output logic [N_CH-1:0] nreset_drive_low,
    output logic [N_CH-1:0] busy,
    input  logic [7:0]      led_conf,
    input  logic            pll_ready,
    input  logic            resync_active,
    input  logic            adv_ready,
    output logic            status_led_oe,
    output logic            status_led_val
);

    localparam int              CW        = $clog2(PULSE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(PULSE_CYCLES - 1);
    localparam ch_state_t       RST_STATE = POWERON_ASSERT ? CH_ASSERT : CH_IDLE;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ch_state_t     state, state_nxt;
        logic [CW-1:0] cnt, cnt_nxt;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state <= RST_STATE;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        // A request in ASSERT, even on the last cycle, restarts the full low time.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = '0;
            case (state)
                CH_IDLE: begin
                    if (reset_req[i]) state_nxt = CH_ASSERT;
                end
                CH_ASSERT: begin
                    if (reset_req[i])         cnt_nxt   = '0;
                    else if (cnt == CNT_LAST) state_nxt = CH_IDLE;
                    else                      cnt_nxt   = cnt + CW'(1);
                end
                default: state_nxt = CH_IDLE;
            endcase
        end

        assign nreset_drive_low[i] = (state == CH_ASSERT);
    end

    assign busy = nreset_drive_low;

    logic slow_glow;
    logic fast_glow;

    led_glow_pwm #(
        .SLOW_BITPOS (SLOW_BITPOS),
        .FAST_BITPOS (FAST_BITPOS)
    ) u_glow (
        .clock     (clock),
        .reset     (reset),
        .slow_glow (slow_glow),
        .fast_glow (fast_glow)
    );

    logic led_oe_nxt;
    logic led_val_nxt;

    always_comb begin
        led_oe_nxt  = 1'b0;
        led_val_nxt = 1'b0;
        if (led_conf == LED_CONF_STATUS) begin
            led_oe_nxt = 1'b1;
            if (!pll_ready)         led_val_nxt = 1'b1;
            else if (resync_active) led_val_nxt = ~fast_glow;
            else if (adv_ready)     led_val_nxt = 1'b0;
            else                    led_val_nxt = ~slow_glow;
        end else begin
            // Mirror: LED pulled low only while the selected channel is asserting.
            for (int c = 0; c < N_CH; c++) begin
                if (led_conf == 8'(c + 1)) led_oe_nxt = nreset_drive_low[c];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            status_led_oe  <= 1'b0;
            status_led_val <= 1'b0;
        end else begin
            status_led_oe  <= led_oe_nxt;
            status_led_val <= led_val_nxt;
        end
    end

endmodule

// File: tb/tb_reset_pulse_ctrl.sv
// Directed + random bench: two instances (power-on assert off/on) against a remaining-time model.
module tb_reset_pulse_ctrl;

    localparam int N_CH = 2;
    localparam int PC   = 8;
    localparam int SLOW = 10;
    localparam int FAST = 9;
    localparam int GMOD = 1 << (SLOW + 1);

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N_CH-1:0] reset_req = '0;
    logic [7:0]      led_conf = 8'd0;
    logic            pll_ready = 1'b0;
    logic            resync_active = 1'b0;
    logic            adv_ready = 1'b0;

    logic [N_CH-1:0] dl0, busy0, dl1, busy1;
    logic            oe0, val0, oe1, val1;

    reset_pulse_ctrl #(
        .N_CH(N_CH), .PULSE_CYCLES(PC), .POWERON_ASSERT(1'b0),
        .SLOW_BITPOS(SLOW), .FAST_BITPOS(FAST)
    ) dut (
        .clock(clock), .reset(reset), .reset_req(reset_req),
        .nreset_drive_low(dl0), .busy(busy0), .led_conf(led_conf),
        .pll_ready(pll_ready), .resync_active(resync_active), .adv_ready(adv_ready),
        .status_led_oe(oe0), .status_led_val(val0)
    );

    reset_pulse_ctrl #(
        .N_CH(N_CH), .PULSE_CYCLES(PC), .POWERON_ASSERT(1'b1),
        .SLOW_BITPOS(SLOW), .FAST_BITPOS(FAST)
    ) dut_po (
        .clock(clock), .reset(reset), .reset_req(reset_req),
        .nreset_drive_low(dl1), .busy(busy1), .led_conf(led_conf),
        .pll_ready(pll_ready), .resync_active(resync_active), .adv_ready(adv_ready),
        .status_led_oe(oe1), .status_led_val(val1)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [N_CH-1:0] drive [2];
        logic            oe    [2];
        logic            val   [2];
    } exp_t;

    exp_t sb[$];
    int   rem [2][N_CH];
    int   gcnt;
    int   tests  = 0;
    int   failed = 0;

    function automatic bit glow(input int c, input int b);
        int lvl;
        lvl = (c >> (b - 8)) & 255;
        if (((c >> b) & 1) == 1) lvl = 255 - lvl;
        return (c & 255) < lvl;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            rem[0][c] = 0;
            rem[1][c] = PC;
        end
        gcnt = 0;
    endtask

    task automatic check_outputs(input exp_t e);
        check("drive0", 8'(dl0),   8'(e.drive[0]));
        check("busy0",  8'(busy0), 8'(e.drive[0]));
        check("drive1", 8'(dl1),   8'(e.drive[1]));
        check("busy1",  8'(busy1), 8'(e.drive[1]));
        check("oe0",    8'(oe0),   8'(e.oe[0]));
        check("val0",   8'(val0),  8'(e.val[0]));
        check("oe1",    8'(oe1),   8'(e.oe[1]));
        check("val1",   8'(val1),  8'(e.val[1]));
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.drive[0] = '0;
        e.drive[1] = '1;
        for (int k = 0; k < 2; k++) begin
            e.oe[k]  = 1'b0;
            e.val[k] = 1'b0;
        end
        return e;
    endfunction

    // Model one clock edge from the inputs currently driven, then compare after it.
    task automatic step();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            e.oe[k]  = 1'b0;
            e.val[k] = 1'b0;
            if (led_conf == 8'd0) begin
                e.oe[k] = 1'b1;
                if (!pll_ready)         e.val[k] = 1'b1;
                else if (resync_active) e.val[k] = !glow(gcnt, FAST);
                else if (adv_ready)     e.val[k] = 1'b0;
                else                    e.val[k] = !glow(gcnt, SLOW);
            end else if (int'(led_conf) <= N_CH) begin
                e.oe[k] = (rem[k][int'(led_conf) - 1] > 0);
            end
        end
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < N_CH; c++) begin
                if (reset_req[c])     rem[k][c] = PC;
                else if (rem[k][c] > 0) rem[k][c] = rem[k][c] - 1;
                e.drive[k][c] = (rem[k][c] > 0);
            end
        gcnt = (gcnt + 1) % GMOD;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check_outputs(e);
        reset_req = '0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs(reset_exp());
        @(posedge clock);
        #1;
        check_outputs(reset_exp());
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, then power-on pulse on the POWERON instance; pll not ready -> LED on.
        model_reset();
        @(posedge clock);
        #1;
        pulse_reset();
        run(12);

        // Single pulse on channel 0.
        reset_req = 2'b01; step();
        run(12);

        // Retrigger mid-pulse.
        reset_req = 2'b01; step();
        run(4);
        reset_req = 2'b01; step();
        run(12);

        // Retrigger on the final asserted cycle.
        reset_req = 2'b01; step();
        run(7);
        reset_req = 2'b01; step();
        run(12);

        // Mirror channel 1, then out-of-range selection.
        led_conf = 8'd2;
        reset_req = 2'b10; step();
        run(12);
        led_conf = 8'd3;
        reset_req = 2'b11; step();
        run(10);
        led_conf = 8'd1;
        reset_req = 2'b01; step();
        run(10);

        // Status LED: resync shows fast glow over a full fast period.
        led_conf = 8'd0;
        pll_ready = 1'b1;
        resync_active = 1'b1;
        run(1100);
        adv_ready = 1'b1;
        resync_active = 1'b0;
        run(10);
        adv_ready = 1'b0;
        run(4100);

        // Simultaneous requests interrupted by asynchronous reset.
        reset_req = 2'b11; step();
        run(2);
        pulse_reset();
        run(12);

        // Random mix.
        for (int i = 0; i < 300; i++) begin
            reset_req     = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            led_conf      = 8'($urandom_range(0, 4));
            pll_ready     = ($urandom_range(0, 7) != 0);
            resync_active = 1'($urandom_range(0, 1));
            adv_ready     = 1'($urandom_range(0, 1));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
